// File: rtl/pygmy_pkg.sv
// Shared definitions for the pygmy pipeline: load funct3 encodings and the
// write-back stage state type.
package pygmy_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_stage_if.sv
// Execute-to-write-back handshake bundle. The execute stage drives the
// master side; the write-back stage is the slave and returns ready_o.
interface wb_stage_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic            ready_o;
    logic            reg_write_i;
    logic            is_load_i;
    logic [2:0]      funct3_i;
    logic [4:0]      rd_ptr_i;
    logic [XLEN-1:0] alu_result_i;

    modport master (
        output valid_i, reg_write_i, is_load_i, funct3_i, rd_ptr_i, alu_result_i,
        input  ready_o
    );

    modport slave (
        input  valid_i, reg_write_i, is_load_i, funct3_i, rd_ptr_i, alu_result_i,
        output ready_o
    );
endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load aligner: selects and extends the addressed byte/halfword
// of a word-aligned data word, and flags misaligned or unknown load sizes.
module load_align
    import pygmy_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] value,
    output logic            err
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = data[7:0];
            2'd1:    byte_sel = data[15:8];
            2'd2:    byte_sel = data[23:16];
            default: byte_sel = data[31:24];
        endcase
        half_sel = addr[1] ? data[31:16] : data[15:0];
    end

    always_comb begin
        value = '0;
        err   = 1'b0;
        case (funct3)
            LB:  value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LH: begin
                value = {{(XLEN-16){half_sel[15]}}, half_sel};
                err   = addr[0];
            end
            LW: begin
                value = data;
                err   = (addr != 2'd0);
            end
            LBU: value = {{(XLEN-8){1'b0}}, byte_sel};
            LHU: begin
                value = {{(XLEN-16){1'b0}}, half_sel};
                err   = addr[0];
            end
            // Reserved load sizes are treated like a misaligned access.
            default: err = 1'b1;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: commits ALU results and aligned load data to the register
// file, one instruction at a time. Define WB_BYPASS_EN to add forwarding ports.
module wb_stage
    import pygmy_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    wb_stage_if.slave       ex,
    input  logic            mem_ack_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            reg_write_en_o,
    output logic [4:0]      rd_ptr_o,
    output logic [XLEN-1:0] rd_o,
    output logic            retire_o,
    output logic            load_err_o
`ifdef WB_BYPASS_EN
    ,
    output logic            fwd_valid_o,
    output logic [4:0]      fwd_ptr_o,
    output logic [XLEN-1:0] fwd_data_o
`endif
);
    wb_state_t       state_reg;
    logic [4:0]      ptr_reg;
    logic [2:0]      f3_reg;
    logic [1:0]      addr_reg;
    logic            wr_reg;

    logic            accept;
    logic [2:0]      al_f3;
    logic [1:0]      al_addr;
    logic [XLEN-1:0] al_value;
    logic            al_err;

    logic            commit_now;
    logic            commit_wr;
    logic            load_fault;
    logic [4:0]      commit_ptr;
    logic [XLEN-1:0] commit_data;

    assign ex.ready_o = (state_reg == IDLE);
    assign accept     = ex.valid_i & ex.ready_o;

    // One aligner serves both uses: legality check on the incoming request
    // while idle, data alignment from the latched fields while waiting.
    always_comb begin
        if (state_reg == IDLE) begin
            al_f3   = ex.funct3_i;
            al_addr = ex.alu_result_i[1:0];
        end else begin
            al_f3   = f3_reg;
            al_addr = addr_reg;
        end
    end

    load_align #(.XLEN(XLEN)) u_align (
        .funct3 (al_f3),
        .addr   (al_addr),
        .data   (mem_rdata_i),
        .value  (al_value),
        .err    (al_err)
    );

    always_comb begin
        commit_now  = 1'b0;
        commit_wr   = 1'b0;
        commit_ptr  = ex.rd_ptr_i;
        commit_data = ex.alu_result_i;
        load_fault  = accept & ex.is_load_i & al_err;
        if (accept && !ex.is_load_i) begin
            commit_now = 1'b1;
            commit_wr  = ex.reg_write_i & (ex.rd_ptr_i != 5'd0);
        end else if (state_reg == WAIT_MEM && mem_ack_i) begin
            commit_now  = 1'b1;
            commit_ptr  = ptr_reg;
            commit_data = al_value;
            commit_wr   = wr_reg & (ptr_reg != 5'd0);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            f3_reg         <= '0;
            addr_reg       <= '0;
            wr_reg         <= 1'b0;
            reg_write_en_o <= 1'b0;
            rd_ptr_o       <= '0;
            rd_o           <= '0;
            retire_o       <= 1'b0;
            load_err_o     <= 1'b0;
        end else begin
            reg_write_en_o <= commit_wr;
            retire_o       <= commit_now | load_fault;
            load_err_o     <= load_fault;
            if (commit_now) begin
                rd_ptr_o <= commit_ptr;
                rd_o     <= commit_data;
            end
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (ex.is_load_i && !al_err) begin
                            ptr_reg   <= ex.rd_ptr_i;
                            f3_reg    <= ex.funct3_i;
                            addr_reg  <= ex.alu_result_i[1:0];
                            wr_reg    <= ex.reg_write_i;
                            state_reg <= WAIT_MEM;
                        end else begin
                            state_reg <= COMMIT;
                        end
                    end
                end
                WAIT_MEM: if (mem_ack_i) state_reg <= COMMIT;
                COMMIT:   state_reg <= IDLE;
                default:  state_reg <= IDLE;
            endcase
        end
    end

`ifdef WB_BYPASS_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fwd_valid_o <= 1'b0;
            fwd_ptr_o   <= '0;
            fwd_data_o  <= '0;
        end else if (commit_wr) begin
            fwd_valid_o <= 1'b1;
            fwd_ptr_o   <= commit_ptr;
            fwd_data_o  <= commit_data;
        end
    end
`endif
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 valid_i  in  1  execute result valid.
REQ-005 ready_o  out  1  stage accepts; a transfer occurs when valid_i & ready_o.
REQ-006 reg_write_i  in  1  instruction writes rd.
REQ-007 is_load_i  in  1  instruction is a load.
REQ-008 funct3_i  in  3  load size/sign encoding.
REQ-009 rd_ptr_i  in  5  destination register index.
REQ-010 alu_result_i  in  XLEN  ALU result, or load byte address.
REQ-011 mem_ack_i  in  1  load data valid from data memory.
REQ-012 mem_rdata_i  in  XLEN  word-aligned load data.
REQ-013 reg_write_en_o  out  1  register-file write enable, registered.
REQ-014 rd_ptr_o  out  5  register-file write index, registered.
REQ-015 rd_o  out  XLEN  register-file write data, registered.
REQ-016 retire_o  out  1  one-cycle pulse per completed instruction.
REQ-017 load_err_o  out  1  one-cycle pulse on a misaligned or illegal load.

Function
REQ-018 The FSM has three states: IDLE, WAIT_MEM, COMMIT.
REQ-019 ready_o is 1 only in IDLE.
REQ-020 IDLE, accepted non-load: go to COMMIT; write alu_result_i to rd; the write is visible on the outputs exactly 1 cycle after acceptance.
REQ-021 IDLE, accepted legal aligned load: latch rd_ptr, funct3 and addr[1:0], then go to WAIT_MEM.
REQ-022 WAIT_MEM: mem_ack_i is ignored in every other state.
REQ-023 WAIT_MEM with mem_ack_i=1: align mem_rdata_i and go to COMMIT.
REQ-024 WAIT_MEM with mem_ack_i=0: hold state, ready_o=0.
REQ-025 COMMIT lasts exactly one cycle, drives retire_o=1, then returns to IDLE.
REQ-026 In COMMIT, reg_write_en_o = reg_write & (rd_ptr != 0).
REQ-027 Load alignment by funct3:
  - 000 LB: sign-extend byte addr[1:0].
  - 001 LH: sign-extend halfword addr[1].
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extend the same selections.
REQ-028 Misaligned load (LH/LHU with addr[0]=1; LW with addr[1:0]!=0): go to COMMIT directly, no write, retire_o=1, load_err_o=1.
REQ-029 funct3 011, 110 or 111 with is_load_i: handled exactly as misaligned.
REQ-030 rd_ptr=0: no write, but retire_o still pulses.
REQ-031 reg_write_en_o, retire_o and load_err_o are 0 outside COMMIT.
REQ-032 rd_ptr_o and rd_o hold their last values when not committing.

Reset
REQ-033 rstn_i low forces IDLE; all outputs 0 except ready_o, which is 1.
REQ-034 Reset asserted in WAIT_MEM or COMMIT discards the pending instruction: no write, no retire.
REQ-035 The first cycle after reset release accepts normally.

Configuration
REQ-036 WB_BYPASS_EN defined: add ports fwd_valid_o (1), fwd_ptr_o (5), fwd_data_o (XLEN).
  - They hold the most recent committed nonzero-rd write and update in the same cycle as reg_write_en_o.
  - Reset clears them to 0.
REQ-037 WB_BYPASS_EN undefined: these ports and their registers do not exist; all other behaviour is identical.

Structure
REQ-038 A shared package pygmy_pkg holds:
  - the load funct3 constants (LB, LH, LW, LBU, LHU);
  - the wb_state_t enum.
REQ-039 One combinational sub-module, load_align, takes funct3, addr[1:0] and the data word, and produces the aligned value and an error flag.

Verification
REQ-040 Non-load: ALU result 0x1234_5678 to rd=5 -> next cycle reg_write_en_o=1, rd_ptr_o=5, rd_o=0x1234_5678, retire_o=1.
REQ-041 LB at addr 0x...3, rdata 0x80FF_FFFF, mem_ack_i 3 cycles later -> rd_o=0xFFFF_FF80 one cycle after the ack; ready_o=0 throughout the wait.
REQ-042 LHU at addr 0x...2, rdata 0x8001_0000 -> rd_o=0x0000_8001.
REQ-043 LW at addr 0x...1 -> no write, load_err_o=1 and retire_o=1 one cycle after acceptance; mem_ack_i not required.
REQ-044 Non-load to rd=0 -> reg_write_en_o=0, retire_o=1.
REQ-045 rstn_i pulsed low during WAIT_MEM, then mem_ack_i=1 -> no write, no retire, ready_o=1.
